// File: rtl/lupa_pkg.sv
// rtl/lupa_pkg.sv - shared types, defaults and pixel conversion for the LUPA300 frame capture path
package lupa_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2,
      DONE       = 2'd3
   } state_e;

   localparam int H_ACTIVE_DEF    = 640;
   localparam int V_ACTIVE_DEF    = 480;
   localparam int CAPTURE_IDX_DEF = 2;

   // The FIFO consumer expects inverted 8-bit video: keep the MSBs, flip polarity.
   function automatic logic [7:0] pix_to_byte(input logic [9:0] pix);
      return ~pix[9:2];
   endfunction

endpackage

// File: rtl/lupa_frame_capture_if.sv
// rtl/lupa_frame_capture_if.sv - sensor bus, host arm and FIFO write-side signals of the capture stage
interface lupa_frame_capture_if;

   logic [9:0]  DATA_IMAGE;
   logic        LINE_VALID;
   logic        FRAME_VALID;
   logic        arm;
   logic        fifo_full;
   logic [31:0] fifo_din;
   logic        fifo_wr_en;
   logic        busy;
   logic        frame_done;
   logic        overflow;

   modport slave (
      input  DATA_IMAGE, LINE_VALID, FRAME_VALID, arm, fifo_full,
      output fifo_din, fifo_wr_en, busy, frame_done, overflow
   );

   modport master (
      output DATA_IMAGE, LINE_VALID, FRAME_VALID, arm, fifo_full,
      input  fifo_din, fifo_wr_en, busy, frame_done, overflow
   );

endinterface

// File: rtl/lupa_pix_packer.sv
// rtl/lupa_pix_packer.sv - packs four bytes per 32-bit word, first byte in [7:0], zero-pads on flush
module lupa_pix_packer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        flush_i,
   input  logic        byte_vld_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_vld_o
);

   logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic        word_vld_q, word_vld_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         b0_q       <= '0;
         b1_q       <= '0;
         b2_q       <= '0;
         idx_q      <= '0;
         word_q     <= '0;
         word_vld_q <= 1'b0;
      end else begin
         b0_q       <= b0_d;
         b1_q       <= b1_d;
         b2_q       <= b2_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         word_vld_q <= word_vld_d;
      end
   end

   // Held bytes are zeroed after every emitted word, so a flush pads with 0x00 for free.
   always_comb begin
      b0_d       = b0_q;
      b1_d       = b1_q;
      b2_d       = b2_q;
      idx_d      = idx_q;
      word_d     = word_q;
      word_vld_d = 1'b0;
      if (clear_i) begin
         b0_d  = '0;
         b1_d  = '0;
         b2_d  = '0;
         idx_d = '0;
      end else if (byte_vld_i) begin
         idx_d = idx_q + 2'd1;
         case (idx_q)
            2'd0: b0_d = byte_i;
            2'd1: b1_d = byte_i;
            2'd2: b2_d = byte_i;
            default: begin
               word_d     = {byte_i, b2_q, b1_q, b0_q};
               word_vld_d = 1'b1;
               b0_d       = '0;
               b1_d       = '0;
               b2_d       = '0;
            end
         endcase
      end else if (flush_i && (idx_q != 2'd0)) begin
         word_d     = {8'h00, b2_q, b1_q, b0_q};
         word_vld_d = 1'b1;
         b0_d       = '0;
         b1_d       = '0;
         b2_d       = '0;
         idx_d      = '0;
      end
   end

   assign word_o     = word_q;
   assign word_vld_o = word_vld_q;

endmodule

// File: rtl/lupa_frame_capture.sv
// rtl/lupa_frame_capture.sv - qualifies LUPA300 frames/lines, windows one armed frame and writes packed words to the FIFO
module lupa_frame_capture
   import lupa_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int CAPTURE_IDX = CAPTURE_IDX_DEF
) (
   input logic                  iCLOCK_80,
   input logic                  RST_N,
   lupa_frame_capture_if.slave  bus
);

   localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
   localparam logic [9:0]  V_LIM   = 10'(V_ACTIVE);
   localparam logic [9:0]  V_SAT   = 10'(V_ACTIVE + 1);
   localparam logic [3:0]  CAP_LIM = 4'(CAPTURE_IDX);

   logic [9:0]  dat_q;
   logic        lv_q, fv_q, lv_p_q, fv_p_q, arm_q;
   state_e      state_q, state_d;
   logic [3:0]  frame_cnt_q, frame_cnt_d;
   logic [9:0]  line_cnt_q, line_cnt_d;
   logic [10:0] pix_cnt_q, pix_cnt_d;
   logic        overflow_q, overflow_d;
   logic        frame_done_q, frame_done_d;

   logic        lv_rise, lv_fall, fv_rise, fv_fall, arm_rise;
   logic        capturing, pk_clear, pk_flush, pix_keep;
   logic [9:0]  line_nxt, line_eff;
   logic [10:0] pix_eff;
   logic [31:0] pk_word;
   logic        pk_word_vld, wr_gate;

   // Sensor outputs are launched on our own clock, so a single register stage is enough.
   always_ff @(posedge iCLOCK_80 or negedge RST_N) begin
      if (!RST_N) begin
         dat_q        <= '0;
         lv_q         <= 1'b0;
         fv_q         <= 1'b0;
         lv_p_q       <= 1'b0;
         fv_p_q       <= 1'b0;
         arm_q        <= 1'b0;
         state_q      <= IDLE;
         frame_cnt_q  <= '0;
         line_cnt_q   <= '0;
         pix_cnt_q    <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         dat_q        <= bus.DATA_IMAGE;
         lv_q         <= bus.LINE_VALID;
         fv_q         <= bus.FRAME_VALID;
         lv_p_q       <= lv_q;
         fv_p_q       <= fv_q;
         arm_q        <= bus.arm;
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         line_cnt_q   <= line_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign lv_rise  = lv_q & ~lv_p_q;
   assign lv_fall  = ~lv_q & lv_p_q;
   assign fv_rise  = fv_q & ~fv_p_q;
   assign fv_fall  = ~fv_q & fv_p_q;
   assign arm_rise = bus.arm & ~arm_q;

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;
      capturing    = 1'b0;
      pk_clear     = 1'b0;
      pk_flush     = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm_rise) begin
               state_d     = WAIT_FRAME;
               frame_cnt_d = '0;
            end
         end
         WAIT_FRAME: begin
            if (!bus.arm) begin
               state_d  = IDLE;
               pk_clear = 1'b1;
            end else if (fv_rise) begin
               frame_cnt_d = frame_cnt_q + 4'd1;
               if (frame_cnt_q + 4'd1 == CAP_LIM) begin
                  state_d   = CAPTURE;
                  capturing = 1'b1;
               end
            end
         end
         CAPTURE: begin
            if (!bus.arm) begin
               state_d  = IDLE;
               pk_clear = 1'b1;
            end else begin
               capturing = 1'b1;
               pk_flush  = lv_fall | fv_fall;
               if (fv_fall) begin
                  state_d      = DONE;
                  frame_done_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (!bus.arm) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The pixel on dat_q in the LV rising cycle is pixel 0 of the new line.
   always_comb begin
      line_nxt   = (line_cnt_q == V_SAT) ? line_cnt_q : line_cnt_q + 10'd1;
      line_eff   = lv_rise ? line_nxt : line_cnt_q;
      pix_eff    = lv_rise ? 11'd0 : pix_cnt_q;
      line_cnt_d = fv_q ? line_eff : 10'd0;
      pix_cnt_d  = (lv_q && (pix_eff < H_LIM)) ? pix_eff + 11'd1 : pix_eff;
      pix_keep   = lv_q && fv_q && (line_eff != 10'd0) && (line_eff <= V_LIM) && (pix_eff < H_LIM);
   end

   lupa_pix_packer u_packer (
      .clk_i      (iCLOCK_80),
      .rst_ni     (RST_N),
      .clear_i    (pk_clear),
      .flush_i    (pk_flush),
      .byte_vld_i (capturing & pix_keep),
      .byte_i     (pix_to_byte(dat_q)),
      .word_o     (pk_word),
      .word_vld_o (pk_word_vld)
   );

   // Dropping arm stops writes in the same cycle; the end-of-frame flush lands in DONE.
   assign wr_gate = bus.arm | (state_q == DONE);

   always_comb begin
      overflow_d = overflow_q;
      if (arm_rise) overflow_d = 1'b0;
      if (pk_word_vld && bus.fifo_full && wr_gate) overflow_d = 1'b1;
   end

   assign bus.fifo_din   = pk_word;
   assign bus.fifo_wr_en = pk_word_vld & ~bus.fifo_full & wr_gate;
   assign bus.busy       = (state_q == WAIT_FRAME) || (state_q == CAPTURE);
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;

endmodule
